// File: rtl/data_memory_if.sv
// Load/store port between the core (master) and the data RAM (slave).
// Request channel: valid/ready with we, funct3, address and store data.
// Response channel: valid/ready with extended load data and an error flag.
interface data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM answering the core's load/store port.
// One request at a time: IDLE accepts, ACCESS reads/writes the array and
// builds the response, RESP holds it until the core takes it.
// Misaligned, out-of-range and illegal-width accesses respond with an error
// and leave the array untouched.
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    data_memory_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] WORD_LIMIT = 30'(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the access must be rejected without touching memory.
    function automatic logic access_error(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr[0];
            F3_W:    err = (addr[1:0] != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | addr[0];
            default: err = 1'b1;
        endcase
        return err | (addr[31:2] >= WORD_LIMIT);
    endfunction

    // Merge store data into the old word; untouched lanes keep their bytes.
    function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] merged;
        merged = old_word;
        case (f3)
            F3_B: begin
                case (off)
                    2'b00:   merged[7:0]   = wdata[7:0];
                    2'b01:   merged[15:8]  = wdata[7:0];
                    2'b10:   merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (off[1]) merged[31:16] = wdata[15:0];
                else        merged[15:0]  = wdata[15:0];
            end
            F3_W:    merged = wdata;
            default: merged = old_word;
        endcase
        return merged;
    endfunction

    // Pick the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, b};
            F3_HU:   res = {16'h0000, h};
            default: res = 32'h00000000;
        endcase
        return res;
    endfunction

    logic [1:0]  state_q,     state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        we_q,        we_d;
    logic [2:0]  funct3_q,    funct3_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] wdata_q,     wdata_d;

    logic [31:0] mem_q [0:DEPTH_WORDS-1];

    logic [AW-1:0] word_idx_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   merged_s;
    logic          err_s;
    logic          mem_we_s;

    assign word_idx_s = addr_q[AW+1:2];
    assign rd_word_s  = mem_q[word_idx_s];
    assign err_s      = access_error(we_q, funct3_q, addr_q);
    assign merged_s   = merge_store(rd_word_s, wdata_q, funct3_q, addr_q[1:0]);
    // Only a legal store commits, and only on its ACCESS edge; a reset that
    // lands during ACCESS forces IDLE so the write is dropped.
    assign mem_we_s   = (state_q == ST_ACCESS) & we_q & ~err_s & reset_n;

    // Next-state and response computation for the three-state handshake.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    funct3_d    = bus.req_funct3;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
                if (err_s) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'h00000000;
                end else if (we_q) begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h00000000;
                end else begin
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_extend(rd_word_s, funct3_q, addr_q[1:0]);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Control/response registers; async reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h00000000;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h00000000;
            wdata_q     <= 32'h00000000;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // Storage array write port; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[word_idx_s] <= merged_s;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data RAM that services the core's load/store port as the responder, or slave, side of a valid/ready request/response handshake. It accepts one request at a time and performs SB/SH/SW stores with byte-lane merging. It performs LB/LH/LW/LBU/LHU loads with sign or zero extension. Misaligned, out-of-range and illegal-width accesses return an error response instead of touching memory.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; word index = `req_addr[31:2]`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low bits are used for B/H.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: core accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access rejected.

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1, `rsp_valid`=0.
  - When `req_valid` & `req_ready`: capture `we`/`funct3`/`addr`/`wdata` into registers, go to ACCESS.
- **ACCESS** (`req_ready`=0)
  - Evaluate the captured request. It is an error if any of the following hold:
    - funct3 ∉ {000,001,010,100,101};
    - a store with funct3 100/101;
    - H/HU with `addr[0]`≠0;
    - W with `addr[1:0]`≠0;
    - `addr[31:2]` ≥ `DEPTH_WORDS`.
  - On error: no memory write; `rsp_err`=1, `rsp_rdata`=0.
  - Store: write only the addressed lane(s).
    - B writes `wdata[7:0]` to byte `addr[1:0]`.
    - H writes `wdata[15:0]` to bits [15:0] if `addr[1]`=0, else [31:16].
    - W writes all 32 bits. Other bytes are unchanged.
    - `rsp_rdata`=0.
  - Load: select the byte or half by `addr[1:0]`/`addr[1]`. B/H sign-extend from bit 7/15; BU/HU zero-extend; W is passed through.
  - Go to RESP with `rsp_valid`=1.
- **RESP**
  - Hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`=1 at a rising edge.
  - Then go to IDLE: `rsp_valid`→0, `rsp_err`→0, `rsp_rdata` retained.
- **Reset** (`reset_n`=0, any time, asynchronous)
  - State → IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - In-flight request dropped; a store still in ACCESS is not committed.
  - The memory array is not cleared; its contents are undefined after power-up.
- Only one outstanding request; `req_*` is ignored outside IDLE.

## Timing
- Request handshake at edge k → memory read/write at edge k+1 → `rsp_valid` high from k+1.
- Response handshake at the earliest edge k+2; `req_ready` high again after it.
- Minimum 3 cycles per transaction.
- Load-after-store to the same word returns the new data (the store commits at its ACCESS edge, before the next accept).
- Outputs are registered; there is no combinational path from `req_*` or `rsp_ready` to any output.
- `rsp_ready` held 0 stalls indefinitely in RESP with outputs stable.
- `rsp_ready`=1 during IDLE/ACCESS has no effect.
- `reset_n` deassertion is synchronous to the design; the first request can be accepted at the first edge after release.

## Test plan
- **Reset values:** hold `reset_n`=0 → `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. Release it, then send SW 0xDEADBEEF to 0x10 followed by LW 0x10 → `rdata` 0xDEADBEEF, `err`=0, `rsp_valid` high exactly one edge after the request accept.
- **Byte lanes:** SW 0x00000000 to 0x20, then SB 0x80 to 0x23 and SH 0x1234 to 0x20.
  - LW 0x20 → 0x80001234.
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF8000.
  - LHU 0x20 → 0x00001234.
- **Errors:** LW 0x22, SH 0x21, SB to 0x400 (word 256, DEPTH_WORDS=256), and a store with funct3 100 → each gives `rsp_err`=1, `rdata`=0. A following LW of each targeted word shows it unchanged.
- **Back-pressure:** hold `rsp_ready`=0 for 5 cycles after LW → `rsp_valid`/`rdata` stable and `req_ready`=0 throughout. A second `req_valid` pulse during that time is not accepted. Raising `rsp_ready` completes the response, and the next request is accepted on the edge after.
- **Reset mid-operation:** assert `reset_n`=0 while in ACCESS of SW 0xFFFFFFFF to 0x30 (previously 0x11111111) → outputs return to reset values immediately. A later LW 0x30 → 0x11111111.
- **Back-to-back:** 16 alternating random SW/LW pairs with `rsp_ready`=1 → every response matches a reference model, at one transaction per 3 cycles.
